// File: rtl/cla_carry_resolver.sv
// Two-stage carry resolver for the 32-bit carry-lookahead adder: S1 resolves group carries, S2 resolves bit carries and the sum.
// Optional build macro CLA_RESOLVE_CHECK_EN adds a sticky p/g consistency check driving err.
module cla_carry_resolver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] p,
  input  logic [31:0] g,
  input  logic [7:0]  p_grp,
  input  logic [7:0]  g_grp,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        err
);

  // Flat sum-of-products lookahead over 8 groups: c[k+1] = G[k..j] terms | P[k..0]&c0.
  function automatic logic [8:0] group_carries(input logic [7:0] pv, input logic [7:0] gv,
                                               input logic c0);
    logic [8:0] c;
    logic       term;
    logic       prod;
    c[0] = c0;
    for (int k = 0; k < 8; k++) begin
      term = c0;
      for (int j = 0; j <= k; j++) term = term & pv[j];
      for (int j = 0; j <= k; j++) begin
        prod = gv[j];
        for (int m = j + 1; m <= k; m++) prod = prod & pv[m];
        term = term | prod;
      end
      c[k+1] = term;
    end
    return c;
  endfunction

  // Carries into the four bits of one group; the group's carry-out comes from S1.
  function automatic logic [3:0] bit_carries(input logic [2:0] pv, input logic [2:0] gv,
                                             input logic c0);
    logic [3:0] c;
    logic       term;
    logic       prod;
    c[0] = c0;
    for (int k = 0; k < 3; k++) begin
      term = c0;
      for (int j = 0; j <= k; j++) term = term & pv[j];
      for (int j = 0; j <= k; j++) begin
        prod = gv[j];
        for (int m = j + 1; m <= k; m++) prod = prod & pv[m];
        term = term | prod;
      end
      c[k+1] = term;
    end
    return c;
  endfunction

  logic        s2_adv;
  logic        accept;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_p_q, s1_p_d;
  logic [31:0] s1_g_q, s1_g_d;
  logic [8:0]  s1_cg_q, s1_cg_d;
  logic [31:0] c_vec;
  logic        out_valid_q, out_valid_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output gets a hold/default value first so no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_cg_d    = s1_cg_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_p_d  = p;
      s1_g_d  = g;
      s1_cg_d = group_carries(p_grp, g_grp, cin);
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++)
      c_vec[4*k +: 4] = bit_carries(s1_p_q[4*k +: 3], s1_g_q[4*k +: 3], s1_cg_q[k]);
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = s1_p_q ^ c_vec;
        cout_d = s1_cg_q[8];
        ovf_d  = c_vec[31] ^ s1_cg_q[8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_cg_q     <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_cg_q     <= s1_cg_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

`ifdef CLA_RESOLVE_CHECK_EN
  // Returns {group propagate, group generate} rebuilt from the bit-level p/g.
  function automatic logic [1:0] grp_pg(input logic [3:0] pv, input logic [3:0] gv);
    return {&pv, gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) |
                 (pv[3] & pv[2] & pv[1] & gv[0])};
  endfunction

  logic err_q, err_d;
  logic chk_fail;

  always_comb begin
    chk_fail = |(p & g);
    for (int k = 0; k < 8; k++)
      if ({p_grp[k], g_grp[k]} != grp_pg(p[4*k +: 4], g[4*k +: 4])) chk_fail = 1'b1;
    err_d = err_q | (accept & chk_fail);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_carry_resolver.sv
// Self-checking bench for cla_carry_resolver: directed vector table, random stream with scoreboard,
// mid-flight reset and the p_grp corruption case.
module tb_cla_carry_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p, g;
  logic [7:0]  p_grp, g_grp;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout, ovf, err;

  cla_carry_resolver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .p(p), .g(g), .p_grp(p_grp), .g_grp(g_grp), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

`ifdef CLA_RESOLVE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    res_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] s;
    logic        c31;
    s   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    c31 = a[31] ^ b[31] ^ s[31];
    return '{sum: s[31:0], cout: s[32], ovf: c31 ^ s[32]};
  endfunction

  // Drives p/g and group p/g for a+b+ci; group generate is taken from a 4-bit add.
  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic corrupt);
    logic [4:0] t;
    p   = a ^ b;
    g   = a & b;
    cin = ci;
    for (int k = 0; k < 8; k++) begin
      t        = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
      g_grp[k] = t[4];
      p_grp[k] = &p[4*k +: 4];
    end
    if (corrupt) p_grp[3] = ~p_grp[3];
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] cur_a, cur_b;
    logic        cur_c, holding, held_valid, fire_in, fire_out, exp_ready;
    res_t        held_res, r;
    int          sent, got, cyc;

    vecs[0] = '{a: 32'h0000_0001, b: 32'h0000_0001, cin: 1'b0, exp: '{32'h0000_0002, 1'b0, 1'b0}};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, exp: '{32'h0000_0000, 1'b1, 1'b0}};
    vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, exp: '{32'h8000_0000, 1'b0, 1'b1}};
    vecs[3] = '{a: 32'h0000_0005, b: 32'hFFFF_FFF8, cin: 1'b1, exp: '{32'hFFFF_FFFE, 1'b0, 1'b0}};
    vecs[4] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, exp: '{32'h0000_0000, 1'b1, 1'b1}};
    vecs[5] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b1, exp: '{32'hFFFF_FFFF, 1'b1, 1'b0}};
    vecs[6] = '{a: 32'h1234_5678, b: 32'h1111_1111, cin: 1'b0, exp: '{32'h2345_6789, 1'b0, 1'b0}};
    vecs[7] = '{a: 32'h0000_0000, b: 32'h0000_0000, cin: 1'b1, exp: '{32'h0000_0001, 1'b0, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout_ovf", {cout, ovf}, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;

    // Directed table: one operand at a time, latency of exactly two edges.
    foreach (vecs[i]) begin
      @(negedge clk);
      set_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      in_valid = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check($sformatf("vec%0d_lat1_valid", i), out_valid, 0);
      @(negedge clk);
      #1 check($sformatf("vec%0d_lat2_valid", i), out_valid, 1);
      check($sformatf("vec%0d_result", i), {sum, cout, ovf}, vecs[i].exp);
    end

    // Random stream with random back-pressure, scoreboard, ready and stability checks.
    sent = 0; got = 0; cyc = 0; holding = 1'b0; held_valid = 1'b0;
    cur_a = '0; cur_b = '0; cur_c = 1'b0; held_res = '0;
    while ((sent < 100 || sb.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 99) < 55);
      if (!holding) begin
        if (sent < 100 && $urandom_range(0, 9) < 8) begin
          cur_a = $urandom; cur_b = $urandom; cur_c = $urandom_range(0, 1);
          set_op(cur_a, cur_b, cur_c, 1'b0);
          in_valid = 1'b1;
          holding  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (held_valid) begin
        check("stall_valid", out_valid, 1);
        check("stall_stable", {sum, cout, ovf}, held_res);
      end
      exp_ready = !(sb.size() == 2 && !out_ready);
      check("rand_in_ready", in_ready, exp_ready);
      fire_out = out_valid && out_ready;
      fire_in  = in_valid && in_ready;
      if (fire_out) begin
        if (sb.size() == 0) check("unexpected_output", 1, 0);
        else begin
          r = sb.pop_front();
          check($sformatf("rand_result%0d", got), {sum, cout, ovf}, r);
          got++;
        end
      end
      if (fire_in) begin
        sb.push_back(model(cur_a, cur_b, cur_c));
        sent++;
        holding = 1'b0;
      end
      held_valid = out_valid && !out_ready;
      held_res   = {sum, cout, ovf};
    end
    in_valid = 1'b0;
    check("rand_budget", cyc < 3000, 1);
    check("rand_count", got, 100);

    // Fill both stages under back-pressure, then reset with two operands in flight.
    @(negedge clk);
    out_ready = 1'b0;
    set_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
    @(negedge clk);
    set_op(32'h0000_0050, 32'h0000_0060, 1'b0, 1'b0);
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_first_sum", sum, 32'h0000_0030);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check($sformatf("midrst_no_output%0d", i), out_valid, 0);
    end

    // Corrupted p_grp[3]: err sets after the accepting edge and stays set until reset.
    @(negedge clk);
    set_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    #1 check("clean_err", err, 0);
    set_op(32'h0000_F000, 32'h0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    #1 check("corrupt_err", err, CHK);
    set_op(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1 check("sticky_err", err, CHK);
    check("clean_after_corrupt", {sum, cout, ovf}, {32'h0000_0300, 1'b0, 1'b0});
    rst_n = 1'b0;
    #1 check("err_cleared", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
